// File: rtl/quad_knob_pkg.sv
// Shared types and Gray-code decode helper for the rotary encoder control block.
package quad_knob_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  typedef enum logic [1:0] {
    GS_NONE = 2'd0,
    GS_CW   = 2'd1,
    GS_CCW  = 2'd2,
    GS_ILL  = 2'd3
  } gstep_t;

  // Position of an AB code along the CW cycle 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic gstep_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = gray_idx(cur) - gray_idx(prev);
    case (d)
      2'd0:    return GS_NONE;
      2'd1:    return GS_CW;
      2'd3:    return GS_CCW;
      default: return GS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser on the raw AB pair followed by a run-length glitch filter;
// o_upd pulses for one cycle whenever o_filt_ab takes a new value.
module quad_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_ab,
  output logic [1:0] o_filt_ab,
  output logic       o_upd
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic [1:0]    r_s1, r_s2, r_filt, r_cand;
  logic [CW-1:0] r_cnt;
  logic          r_upd;
  logic [CW-1:0] w_run;

  // A run continues only while the synced value matches the candidate being timed.
  always_comb begin
    w_run = CW'(1);
    if (r_s2 == r_cand && r_cnt != '0) w_run = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      r_cand <= '0;
      r_cnt  <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_s1  <= i_ab;
      r_s2  <= r_s1;
      r_upd <= 1'b0;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (w_run >= CW'(FILT_LEN)) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
        r_upd  <= 1'b1;
      end else begin
        r_cnt  <= w_run;
        r_cand <= r_s2;
      end
    end
  end

  assign o_filt_ab = r_filt;
  assign o_upd     = r_upd;

endmodule

// File: rtl/quad_knob_ctrl.sv
// Rotary encoder control: Gray decode, detent grouping, bounded position and a
// signed net-motion queue presented to the consumer over valid/ready.
module quad_knob_ctrl
  import quad_knob_pkg::*;
#(
  parameter int FILT_LEN  = 4,
  parameter int STEPS_DET = 4,
  parameter int POS_W     = 8,
  parameter int POS_MAX   = 255,
  parameter int WRAP      = 1,
  parameter int PEND_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rota,
  input  logic             rotb,
  input  logic             en,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_load_val,
  output logic             evt_valid,
  output logic             evt_dir,
  input  logic             evt_ready,
  output logic [POS_W-1:0] pos,
  output logic             step_right,
  output logic             step_left,
  output logic [7:0]       err_cnt,
  output logic             ovf,
  input  logic             err_clr
);

  localparam int PW = PEND_W + 2;
  localparam logic signed [3:0]    ACC_TOP  = 4'(STEPS_DET);
  localparam logic [POS_W-1:0]     PMAXV    = POS_W'(POS_MAX);
  localparam logic signed [PW-1:0] ONE      = PW'(1);
  localparam logic signed [PW-1:0] PEND_LIM = PW'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [PW-1:0] NEG_LIM  = -PEND_LIM;

  logic [1:0] w_filt_ab;
  logic       w_upd;

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk       (clk),
    .reset     (reset),
    .i_ab      ({rota, rotb}),
    .o_filt_ab (w_filt_ab),
    .o_upd     (w_upd)
  );

  fsm_t                    r_state;
  logic [1:0]              r_ab_prev;
  logic signed [3:0]       r_acc;
  logic [POS_W-1:0]        r_pos;
  logic signed [PEND_W-1:0] r_pend;
  logic [7:0]              r_err;
  logic                    r_ovf, r_step_r, r_step_l;

  gstep_t                   w_gs;
  logic                     w_cw, w_ccw, w_ill;
  logic signed [3:0]        w_acc_inc, w_acc_dec, w_acc_nxt;
  logic                     w_det_r, w_det_l, w_accept, w_lost;
  logic signed [PW-1:0]     w_pend_x, w_delta, w_pend_sum;
  logic signed [PEND_W-1:0] w_pend_nxt;
  logic [POS_W-1:0]         w_pos_nxt;

  always_comb begin
    w_gs  = gray_step(r_ab_prev, w_filt_ab);
    w_cw  = 1'b0;
    w_ccw = 1'b0;
    w_ill = 1'b0;
    if (w_upd && r_state == ST_RUN && en) begin
      w_cw  = (w_gs == GS_CW);
      w_ccw = (w_gs == GS_CCW);
      w_ill = (w_gs == GS_ILL);
    end
  end

  assign w_acc_inc = r_acc + 4'sd1;
  assign w_acc_dec = r_acc - 4'sd1;
  assign w_det_r   = w_cw  && (w_acc_inc == ACC_TOP);
  assign w_det_l   = w_ccw && (w_acc_dec == -ACC_TOP);

  always_comb begin
    w_acc_nxt = r_acc;
    if (!en || pos_load || w_ill || w_det_r || w_det_l) w_acc_nxt = '0;
    else if (w_cw)                                      w_acc_nxt = w_acc_inc;
    else if (w_ccw)                                     w_acc_nxt = w_acc_dec;
  end

  // A load wins over a detent; the detent still reaches the event queue and pulses.
  always_comb begin
    w_pos_nxt = r_pos;
    if (pos_load)
      w_pos_nxt = (pos_load_val > PMAXV) ? PMAXV : pos_load_val;
    else if (w_det_r)
      w_pos_nxt = (r_pos >= PMAXV) ? ((WRAP != 0) ? '0 : PMAXV) : r_pos + 1'b1;
    else if (w_det_l)
      w_pos_nxt = (r_pos == '0) ? ((WRAP != 0) ? PMAXV : '0) : r_pos - 1'b1;
  end

  assign w_accept = evt_valid && evt_ready;
  assign w_pend_x = {{2{r_pend[PEND_W-1]}}, r_pend};

  always_comb begin
    w_delta = '0;
    if (w_det_r) w_delta = w_delta + ONE;
    if (w_det_l) w_delta = w_delta - ONE;
    if (w_accept) w_delta = r_pend[PEND_W-1] ? (w_delta + ONE) : (w_delta - ONE);
    w_pend_sum = w_pend_x + w_delta;
    w_lost     = 1'b0;
    w_pend_nxt = w_pend_sum[PEND_W-1:0];
    if (w_pend_sum > PEND_LIM) begin
      w_pend_nxt = PEND_LIM[PEND_W-1:0];
      w_lost     = 1'b1;
    end else if (w_pend_sum < NEG_LIM) begin
      w_pend_nxt = NEG_LIM[PEND_W-1:0];
      w_lost     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_INIT;
      r_ab_prev <= '0;
      r_acc     <= '0;
      r_pos     <= '0;
      r_pend    <= '0;
      r_err     <= '0;
      r_ovf     <= 1'b0;
      r_step_r  <= 1'b0;
      r_step_l  <= 1'b0;
    end else begin
      if (w_upd) begin
        r_ab_prev <= w_filt_ab;
        if (r_state == ST_INIT) r_state <= ST_RUN;
      end
      r_acc    <= w_acc_nxt;
      r_pos    <= w_pos_nxt;
      r_pend   <= w_pend_nxt;
      r_step_r <= w_det_r;
      r_step_l <= w_det_l;
      if (err_clr) begin
        r_err <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_ill && r_err != 8'hFF) r_err <= r_err + 8'd1;
        if (w_lost)                  r_ovf <= 1'b1;
      end
    end
  end

  assign evt_valid  = (r_pend != '0);
  assign evt_dir    = (evt_valid && !r_pend[PEND_W-1]) ? DIR_RIGHT : DIR_LEFT;
  assign pos        = r_pos;
  assign step_right = r_step_r;
  assign step_left  = r_step_l;
  assign err_cnt    = r_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_quad_knob_ctrl.sv
// Randomised and directed bench for quad_knob_ctrl: a wrapping and a saturating instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_quad_knob_ctrl;

  localparam int FL = 4;
  localparam int SD = 4;
  localparam int PLIM = 7;
  localparam int MAX_W = 255;
  localparam int MAX_S = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rota = 1'b0, rotb = 1'b0, en = 1'b1, pos_load = 1'b0;
  logic       evt_ready = 1'b0, err_clr = 1'b0;
  logic [7:0] pos_load_val = '0;

  logic       vld_w, dir_w, sr_w, sl_w, ovf_w;
  logic       vld_s, dir_s, sr_s, sl_s, ovf_s;
  logic [7:0] pos_w, pos_s, err_w, err_s;

  int checks = 0, errors = 0;
  int n_right = 0, n_left = 0;

  always #5 clk = ~clk;

  quad_knob_ctrl u_dut_wrap (
    .clk(clk), .reset(reset), .rota(rota), .rotb(rotb), .en(en), .pos_load(pos_load),
    .pos_load_val(pos_load_val), .evt_valid(vld_w), .evt_dir(dir_w), .evt_ready(evt_ready),
    .pos(pos_w), .step_right(sr_w), .step_left(sl_w), .err_cnt(err_w), .ovf(ovf_w),
    .err_clr(err_clr)
  );

  quad_knob_ctrl #(.WRAP(0), .POS_MAX(MAX_S)) u_dut_sat (
    .clk(clk), .reset(reset), .rota(rota), .rotb(rotb), .en(en), .pos_load(pos_load),
    .pos_load_val(pos_load_val), .evt_valid(vld_s), .evt_dir(dir_s), .evt_ready(evt_ready),
    .pos(pos_s), .step_right(sr_s), .step_left(sl_s), .err_cnt(err_s), .ovf(ovf_s),
    .err_clr(err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_hist[FL+1];
  int m_filt, m_prev, m_acc, m_pos_w, m_pos_s, m_pend, m_err;
  bit m_upd, m_run, m_ovf, m_sr, m_sl;

  function automatic int cw_pos(input int ab);
    int order[4] = '{0, 1, 3, 2};
    for (int i = 0; i < 4; i++) if (order[i] == ab) return i;
    return 0;
  endfunction

  task automatic mreset();
    foreach (m_hist[j]) m_hist[j] = 0;
    m_filt = 0; m_prev = 0; m_acc = 0; m_pos_w = 0; m_pos_s = 0; m_pend = 0; m_err = 0;
    m_upd = 0; m_run = 0; m_ovf = 0; m_sr = 0; m_sl = 0;
  endtask

  task automatic mstep();
    int d, det, p, v;
    bit ill, lost, same;
    det = 0; ill = 0;
    if (m_upd && m_run && en) begin
      d = (cw_pos(m_filt) - cw_pos(m_prev) + 4) % 4;
      if (d == 2) begin ill = 1; m_acc = 0; end
      else if (d == 1) m_acc++;
      else if (d == 3) m_acc--;
      if (m_acc == SD) begin det = 1; m_acc = 0; end
      else if (m_acc == -SD) begin det = -1; m_acc = 0; end
    end
    if (!en || pos_load) m_acc = 0;
    if (m_upd) begin m_prev = m_filt; m_run = 1; end
    p = m_pend + det;
    if (m_pend != 0 && evt_ready) p -= (m_pend > 0) ? 1 : -1;
    lost = 0;
    if (p > PLIM) begin p = PLIM; lost = 1; end
    else if (p < -PLIM) begin p = -PLIM; lost = 1; end
    m_pend = p;
    if (pos_load) begin
      m_pos_w = (int'(pos_load_val) > MAX_W) ? MAX_W : int'(pos_load_val);
      m_pos_s = (int'(pos_load_val) > MAX_S) ? MAX_S : int'(pos_load_val);
    end else if (det == 1) begin
      m_pos_w = (m_pos_w == MAX_W) ? 0 : m_pos_w + 1;
      m_pos_s = (m_pos_s == MAX_S) ? MAX_S : m_pos_s + 1;
    end else if (det == -1) begin
      m_pos_w = (m_pos_w == 0) ? MAX_W : m_pos_w - 1;
      m_pos_s = (m_pos_s == 0) ? 0 : m_pos_s - 1;
    end
    if (err_clr) begin m_err = 0; m_ovf = 0; end
    else begin
      if (ill && m_err < 255) m_err++;
      if (lost) m_ovf = 1;
    end
    m_sr = (det == 1); m_sl = (det == -1);
    // filtered AB follows a raw value that survived FL samples, seen two flops late
    m_upd = 0; v = m_hist[1]; same = 1;
    for (int j = 1; j <= FL; j++) if (m_hist[j] != v) same = 0;
    if (same && v != m_filt) begin m_filt = v; m_upd = 1; end
    for (int j = FL; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = {rota, rotb};
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) mreset();
      else        mstep();
    end
  end

  initial begin
    @(negedge clk);
    forever begin
      chk("pos_wrap", pos_w, m_pos_w);
      chk("pos_sat", pos_s, m_pos_s);
      chk("evt_valid", vld_w, m_pend != 0);
      chk("evt_valid_sat", vld_s, m_pend != 0);
      if (m_pend != 0) begin
        chk("evt_dir", dir_w, m_pend > 0);
        chk("evt_dir_sat", dir_s, m_pend > 0);
      end
      chk("step_right", {sr_w, sr_s}, {m_sr, m_sr});
      chk("step_left", {sl_w, sl_s}, {m_sl, m_sl});
      chk("err_cnt", {err_w, err_s}, {m_err[7:0], m_err[7:0]});
      chk("ovf", {ovf_w, ovf_s}, {m_ovf, m_ovf});
      if (sr_w) n_right++;
      if (sl_w) n_left++;
      @(negedge clk);
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int ci = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ab(input logic [1:0] ab);
    rota = ab[1];
    rotb = ab[0];
  endtask

  task automatic stepc(input bit cw, input int hold);
    ci = (ci + (cw ? 1 : 3)) % 4;
    set_ab(seq[ci]);
    cyc(hold);
  endtask

  task automatic detent(input bit cw);
    repeat (SD) stepc(cw, 10);
  endtask

  task automatic zero_outputs(input string nm);
    chk({nm, "_wrap"}, {pos_w, err_w, vld_w, dir_w, sr_w, sl_w, ovf_w}, 0);
    chk({nm, "_sat"},  {pos_s, err_s, vld_s, dir_s, sr_s, sl_s, ovf_s}, 0);
  endtask

  initial begin
    int n, r, hold;
    logic [7:0] old;
    #1 reset = 1'b0;
    cyc(3);
    zero_outputs("reset");
    reset = 1'b1;
    cyc(2);

    // 1: first filtered change only arms the decoder, then two CW detents
    stepc(1, 10);
    n_right = 0;
    repeat (8) stepc(1, 10);
    cyc(2);
    chk("t1_pos", pos_w, 2);
    chk("t1_pulses", n_right, 2);
    chk("t1_evt", {vld_w, dir_w}, 2'b11);

    // 2: short glitch is rejected; clean edge to pos change latency
    rota = ~rota; cyc(2); rota = ~rota; cyc(10);
    chk("t2_glitch", {err_w, pos_w}, {8'd0, 8'd2});
    repeat (3) stepc(1, 10);
    old = pos_w;
    ci = (ci + 1) % 4; set_ab(seq[ci]);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1; n++;
      if (pos_w !== old) break;
    end
    chk("t2_latency", n, 7);
    cyc(5);

    // 3: wrap versus saturate, load clamping
    pos_load = 1'b1; pos_load_val = 8'd255; cyc(1); pos_load = 1'b0;
    chk("t3_load", {pos_w, pos_s}, {8'd255, 8'd200});
    detent(1);
    chk("t3_cw", {pos_w, pos_s}, {8'd0, 8'd200});
    pos_load = 1'b1; pos_load_val = 8'd0; cyc(1); pos_load = 1'b0;
    n_left = 0;
    detent(0);
    chk("t3_ccw", {pos_w, pos_s}, {8'd255, 8'd0});
    chk("t3_left_pulse", n_left, 1);

    // 4: illegal jumps, mid-detent clearing of acc, clear beating an increment
    ci = (ci + 2) % 4; set_ab(seq[ci]); cyc(10);
    chk("t4_err1", err_w, 1);
    repeat (2) stepc(1, 10);
    ci = (ci + 2) % 4; set_ab(seq[ci]); cyc(10);
    repeat (4) stepc(1, 10);
    chk("t4_err2", err_w, 2);
    ci = (ci + 2) % 4; set_ab(seq[ci]); cyc(6);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0; cyc(5);
    chk("t4_clr", err_w, 0);

    // 5: accept coinciding with a detent, then cancel by opposite motion
    evt_ready = 1'b1;
    n = 0;
    while (vld_w && n < 40) begin cyc(1); n++; end
    evt_ready = 1'b0;
    chk("t5_drain", vld_w, 0);
    detent(1);
    repeat (3) stepc(1, 10);
    ci = (ci + 1) % 4; set_ab(seq[ci]); cyc(6);
    evt_ready = 1'b1; cyc(1); evt_ready = 1'b0; cyc(3);
    chk("t5_hold", {vld_w, dir_w}, 2'b11);
    detent(0);
    chk("t5_cancel", vld_w, 0);

    // 6: saturate the queue, then reset mid-motion
    repeat (8) detent(1);
    chk("t6_ovf", {ovf_w, vld_w, dir_w}, 3'b111);
    repeat (2) stepc(1, 10);
    ci = (ci + 1) % 4; set_ab(seq[ci]); cyc(3);
    #1 reset = 1'b0;
    #1 zero_outputs("t6_reset");
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // random phase
    repeat (600) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        ci = (ci + (($urandom & 1) != 0 ? 1 : 3)) % 4; set_ab(seq[ci]);
      end else if (r < 80) begin
        ci = (ci + 2) % 4; set_ab(seq[ci]);
      end else if (r < 98) begin
        rota = ~rota; cyc($urandom_range(1, 3)); set_ab(seq[ci]);
      end else begin
        #1 reset = 1'b0; cyc(2); reset = 1'b1;
      end
      hold = $urandom_range(1, 12);
      repeat (hold) begin
        en           = ($urandom_range(0, 9) != 0);
        evt_ready    = ($urandom_range(0, 2) == 0);
        pos_load     = ($urandom_range(0, 49) == 0);
        pos_load_val = 8'($urandom);
        err_clr      = ($urandom_range(0, 59) == 0);
        cyc(1);
      end
      pos_load = 1'b0; err_clr = 1'b0;
    end
    cyc(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
